lfsr_sched: RTL and testbench
=============================

# lfsr_sched

Round-robin scheduler sharing one 8-bit maximal-length Fibonacci LFSR engine (taps 8,6,5,4) among `NREQ` requesters. Each granted requester receives a burst of `len` pseudo-random bytes over a valid/ready stream, tagged with its ID. The block also owns seed configuration, deferring seed writes until the engine is idle. It sits between the test/scrambler clients and the PRBS source, replacing direct LFSR instantiation wherever more than one consumer exists.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of `dout_id`; ≥ clog2(NREQ).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req` input NREQ: per-requester burst request, level; held until matching `done` bit.
- `req_len` input 8*NREQ: burst length per requester, slice i = bits [8i+7:8i]; 0 means 256.
- `gnt` output NREQ: one-hot grant, high from GRANT through DONE.
- `done` output NREQ: one-cycle one-hot pulse at burst end.
- `dout` output 8: current LFSR state.
- `dout_vld` output 1: word valid.
- `dout_rdy` input 1: consumer ready.
- `dout_last` output 1: final word of burst.
- `dout_id` output IDW: index of granted requester.
- `seed_we` input 1: seed write strobe.
- `seed` input 8: seed value.
- `busy` output 1: high in any state other than IDLE.

## Operation
- LFSR state `s[7:0]`: `fb = s[0]^s[2]^s[3]^s[4]`; `next = {fb, s[7:1]}`. Reset value 8'h01. Sequence from 8'h01: 01, 80, 40, 20, 10, 88, C4, … with period 255.
- The LFSR advances exactly once per handshake (`dout_vld && dout_rdy`) and never otherwise.
- `dout` = `s` at all times; the value is meaningful only when `dout_vld` is high.
- Seed handling:
  - A `seed_we` pulse captures `seed` into a pending register and sets the pending flag.
  - The pending seed is applied to `s` in the first IDLE cycle, then the flag clears.
  - A seed of 8'h00 is replaced by 8'h01 to avoid lockup.
  - A later `seed_we` overwrites an unapplied pending seed.
- FSM states: IDLE, GRANT, STREAM, DONE.
  - IDLE: if any `req` bit is high, select a winner round-robin starting at pointer `ptr`, then go to GRANT. Otherwise stay in IDLE.
  - GRANT (1 cycle): assert `gnt[w]`, latch `dout_id=w` and `remaining=len` (9-bit; 0 becomes 256), then go to STREAM.
  - STREAM: `dout_vld=1`. On each handshake, `remaining` decrements. `dout_last = (remaining==1)`. A handshake with `dout_last` high goes to DONE.
  - DONE (1 cycle): `done[w]=1`, `ptr = (w+1) mod NREQ`, then go to IDLE.
- `req` deasserting mid-burst is ignored; the burst completes.
- `req_len` is sampled only in GRANT.
- `seed_we` during GRANT, STREAM, or DONE does not affect the running burst.

## Timing
- Reset (asynchronous assert, synchronous release) forces IDLE, `s=8'h01`, `ptr=0`, pending flag clear, and every output to 0, except `dout`, which reads 8'h01.
- Request sampled at IDLE edge *k*: `gnt` high from cycle *k+1*, first `dout_vld` at *k+2*, `done` one cycle after the last handshake. `gnt` drops with `done`.
- Minimum burst-to-burst gap: DONE, then IDLE, then GRANT, for 3 cycles without `dout_vld`.
- `dout_vld` never drops in STREAM before the last handshake.
- `dout`, `dout_last`, and `dout_id` are stable while `dout_vld && !dout_rdy`.
- A seed pending at DONE is applied in the following IDLE cycle, before the next GRANT. The next burst therefore starts from the new seed.
- A reset mid-burst aborts it silently: no `done` pulse, and the pending seed is lost.

## Test plan
- Reset, then `req[0]=1`, `len=6`, `dout_rdy=1` → `dout` = 01,80,40,20,10,88; `dout_last` on 88; `done[0]` the next cycle; `dout_id=0`.
- `req=4'b1111`, all `len=1`, held → grants in order 0,1,2,3,0; consecutive bursts continue the sequence (01,80,40,20,10).
- `len=3`, with `dout_rdy` toggling 1,0,0,1,1 → exactly three words, 01,80,40; `dout` is stable during stalls; the LFSR advances only on handshakes.
- `seed_we` with `seed=8'h88` mid-burst, then a new request → the current burst is unaffected; the next burst starts at 88, C4.
- `seed_we` with `seed=8'h00` while IDLE, then `len=2` → `dout` = 01,80.
- `len=0` → 256 words, `dout_last` on the 256th; assert `rst` low during a second burst → immediate IDLE, all outputs 0, `dout`=01, no `done`.

Source files
------------

// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one 8-bit Fibonacci LFSR (taps 8,6,5,4) among NREQ requesters.
// Each grant streams len bytes tagged with the requester ID; seed writes wait until the engine is idle.
module lfsr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [8*NREQ-1:0]    req_len_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [7:0]           dout_o,
    output logic                 dout_vld_o,
    input  logic                 dout_rdy_i,
    output logic                 dout_last_o,
    output logic [IDW-1:0]       dout_id_o,
    input  logic                 seed_we_i,
    input  logic [7:0]           seed_i,
    output logic                 busy_o
);

    // state  | meaning
    // IDLE   | no burst; pending seed applied, arbitration from ptr
    // GRANT  | winner granted, burst length latched
    // STREAM | words offered on dout, LFSR steps per handshake
    // DONE   | done pulse for winner, pointer moves past it
    typedef enum logic [1:0] {IDLE, GRANT, STREAM, DONE} state_t;

    localparam logic [IDW+1:0] NREQ_W = (IDW+2)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [8:0]      rem_q, rem_d;
    logic            pend_q, pend_d;
    logic [7:0]      pseed_q, pseed_d;

    logic            hs;
    logic            last_word;
    logic            fb;
    logic [2*NREQ-1:0] req_shift;
    logic [IDW:0]    off;
    logic [IDW+1:0]  wsum;
    logic [IDW-1:0]  win_sel;
    logic [7:0]      len_sel;

    assign hs        = (state_q == STREAM) && dout_rdy_i;
    assign last_word = (rem_q == 9'd1);
    assign fb        = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4];

    // Doubling the request vector turns the rotate-by-ptr into a plain shift.
    always_comb begin
        req_shift = {req_i, req_i} >> ptr_q;
        off = '0;
        for (int k = 2*NREQ-1; k >= 0; k--) begin
            if (req_shift[k]) off = (IDW+1)'(k);
        end
        wsum = {2'b00, ptr_q} + {1'b0, off};
        if (wsum >= NREQ_W) wsum = wsum - NREQ_W;
        win_sel = wsum[IDW-1:0];
    end

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q == IDW'(i)) len_sel = req_len_i[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_i) state_d = GRANT;
            GRANT:   state_d = STREAM;
            STREAM:  if (hs && last_word) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o       = '0;
        done_o      = '0;
        dout_vld_o  = 1'b0;
        dout_last_o = 1'b0;
        dout_id_o   = '0;
        busy_o      = (state_q != IDLE);
        dout_o      = lfsr_q;
        if (state_q != IDLE) begin
            gnt_o     = NREQ'(1) << win_q;
            dout_id_o = win_q;
        end
        if (state_q == STREAM) begin
            dout_vld_o  = 1'b1;
            dout_last_o = last_word;
        end
        if (state_q == DONE) done_o = NREQ'(1) << win_q;
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        rem_d   = rem_q;
        pend_d  = pend_q;
        pseed_d = pseed_q;
        if (seed_we_i) begin
            pend_d  = 1'b1;
            pseed_d = seed_i;
        end
        case (state_q)
            IDLE: begin
                // An all-zero seed would lock the LFSR, so it is replaced by 01.
                if (pend_q) begin
                    lfsr_d = (pseed_q == 8'h00) ? 8'h01 : pseed_q;
                    if (!seed_we_i) pend_d = 1'b0;
                end
                if (|req_i) win_d = win_sel;
            end
            GRANT:  rem_d = (len_sel == 8'h00) ? 9'd256 : {1'b0, len_sel};
            STREAM: begin
                if (hs) begin
                    lfsr_d = {fb, lfsr_q[7:1]};
                    rem_d  = rem_q - 9'd1;
                end
            end
            DONE:   ptr_d = (win_q == LAST_ID) ? '0 : win_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q  <= 8'h01;
            ptr_q   <= '0;
            win_q   <= '0;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            pseed_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            pseed_q <= pseed_d;
        end
    end

endmodule

// File: tb/tb_lfsr_sched.sv
// Self-checking bench for lfsr_sched: directed steps plus randomized bursts,
// checked against a transaction-level model of the LFSR, arbiter and seed rules.
module tb_lfsr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   req_len;
    logic [NREQ-1:0]     gnt, done;
    logic [7:0]          dout;
    logic                dout_vld, dout_rdy, dout_last;
    logic [IDW-1:0]      dout_id;
    logic                seed_we;
    logic [7:0]          seed;
    logic                busy;

    lfsr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_len_i(req_len),
        .gnt_o(gnt), .done_o(done), .dout_o(dout), .dout_vld_o(dout_vld),
        .dout_rdy_i(dout_rdy), .dout_last_o(dout_last), .dout_id_o(dout_id),
        .seed_we_i(seed_we), .seed_i(seed), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_s;
    int m_ptr;
    bit m_pend;
    int m_pseed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_step(input int s);
        int b;
        b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 4)) & 1;
        return (s >> 1) | (b << 7);
    endfunction

    function automatic int rr_winner(input int mask);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if ((mask >> idx) & 1) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_s = 1; m_ptr = 0; m_pend = 0; m_pseed = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},  gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dout"}, dout, 8'h01);
        chk({tag, "_vld"},  dout_vld, 0);
        chk({tag, "_last"}, dout_last, 0);
        chk({tag, "_id"},   dout_id, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic set_len(input int i, input int v);
        req_len[8*i +: 8] = v[7:0];
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1,1 then ready
    task automatic serve(input string tag, input int exp_wait, input int rdy_mode,
                         input int seed_at, input int seed_val, input int abort_at);
        int w, len, rem, n, waited;
        int pat[5] = '{1, 0, 0, 1, 1};
        w   = rr_winner(int'(req));
        len = int'(req_len[8*w +: 8]);
        rem = (len == 0) ? 256 : len;
        if (m_pend) begin
            m_s = (m_pseed == 0) ? 1 : m_pseed;
            m_pend = 0;
        end
        tick();
        waited = 1;
        while (gnt == 0 && waited < 8) begin
            chk({tag, "_gap_vld"}, dout_vld, 0);
            tick();
            waited++;
        end
        chk({tag, "_wait"}, waited, exp_wait);
        if (gnt == 0) return;
        chk({tag, "_gnt"},  gnt, 1 << w);
        chk({tag, "_id"},   dout_id, w);
        chk({tag, "_gvld"}, dout_vld, 0);
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (rem > 0) begin
            tick();
            n++;
            if (n > 3000) begin
                checks++; errors++;
                $error("FAIL %s_bound: observed=%0d words expected=%0d", tag, n, len);
                return;
            end
            chk({tag, "_vld"},  dout_vld, 1);
            chk({tag, "_dout"}, dout, m_s);
            chk({tag, "_last"}, dout_last, (rem == 1));
            chk({tag, "_sid"},  dout_id, w);
            chk({tag, "_sgnt"}, gnt, 1 << w);
            if (n - 1 == abort_at) return;
            if (n - 1 == seed_at) begin
                seed_we = 1'b1; seed = seed_val[7:0];
                m_pend = 1; m_pseed = seed_val & 8'hFF;
            end else begin
                seed_we = 1'b0;
            end
            case (rdy_mode)
                0:       dout_rdy = 1'b1;
                1:       dout_rdy = 1'($urandom_range(0, 1));
                default: dout_rdy = (n <= 5) ? 1'(pat[n-1]) : 1'b1;
            endcase
            if (dout_rdy) begin
                m_s = lfsr_step(m_s);
                rem--;
            end
        end
        tick();
        seed_we = 1'b0;
        chk({tag, "_done"},  done, 1 << w);
        chk({tag, "_dgnt"},  gnt, 1 << w);
        chk({tag, "_dvld"},  dout_vld, 0);
        req[w] = 1'b0;
        m_ptr = (w + 1) % NREQ;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs(tag);
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_len = '0; dout_rdy = 1'b0;
        seed_we = 1'b0; seed = '0;
        #12;
        chk_reset_outputs("rst0");
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();

        // basic len=6 burst on requester 0
        set_len(0, 6);
        req = 4'b0001;
        serve("t_basic", 1, 0, -1, 0, -1);

        // all four requesting, len=1, fifth burst re-requests 0
        do_reset("rst1");
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        req = 4'b1111;
        serve("t_rr0", 1, 0, -1, 0, -1);
        for (int i = 1; i < NREQ; i++) serve("t_rr", 2, 0, -1, 0, -1);
        req = 4'b0001;
        serve("t_rr4", 2, 0, -1, 0, -1);

        // stalled burst
        set_len(2, 3);
        req = 4'b0100;
        serve("t_stall", 2, 2, -1, 0, -1);

        // seed written mid-burst applies to the following burst
        set_len(1, 4);
        req = 4'b0010;
        serve("t_seedmid", 2, 0, 1, 8'h88, -1);
        set_len(3, 2);
        req = 4'b1000;
        serve("t_seednext", 2, 0, -1, 0, -1);

        // zero seed while idle becomes 01
        tick();
        seed_we = 1'b1; seed = 8'h00;
        m_pend = 1; m_pseed = 0;
        tick();
        seed_we = 1'b0;
        tick();
        set_len(0, 2);
        req = 4'b0001;
        serve("t_seed0", 1, 0, -1, 0, -1);

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(1, 9));
            req = 4'($urandom_range(1, 15));
            while (req != 0) begin
                if ($urandom_range(0, 2) == 0)
                    serve("t_rand", 2, 1, $urandom_range(0, 5), $urandom_range(0, 255), -1);
                else
                    serve("t_rand", 2, 1, -1, 0, -1);
            end
        end

        // 256-word burst, then reset mid-burst drops both burst and pending seed
        set_len(0, 0);
        req = 4'b0001;
        serve("t_len0", 2, 0, -1, 0, -1);
        set_len(1, 50);
        req = 4'b0010;
        serve("t_abort", 2, 0, 3, 8'h5A, 10);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("t_midrst");
        req = '0; seed_we = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t_nodone", done, 0);
            chk("t_idle_busy", busy, 0);
        end
        set_len(2, 2);
        req = 4'b0100;
        serve("t_after", 1, 0, -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
